// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM
// states and the alignment rule used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // A halfword must sit on an even address, a word on a multiple of four.
  // Bytes never misalign; the reserved size is rejected separately.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Combinational lane logic: picks a byte/half out of a RAM word with sign or
// zero extension for loads, and merges sub-word store data into a word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        zero_ext,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Little-endian lane select followed by extension to 32 bits.
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
    byte_s   = signed'(byte_sel);
    half_s   = signed'(half_sel);
    load_data = word;
    case (size)
      SZ_BYTE: load_data = zero_ext ? {24'h0, byte_sel} : 32'(byte_s);
      SZ_HALF: load_data = zero_ext ? {16'h0, half_sel} : 32'(half_s);
      default: load_data = word;
    endcase
  end

  // Overlay the low byte or half of the store data onto the addressed lane.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata;
        else         merged[15:0]  = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide RAM. Aligns accesses, extracts and
// extends loaded lanes, performs read-modify-write for sub-word stores and
// reports misaligned, reserved-size and out-of-range accesses as faults.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        ram_write_enable,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_set_val,
  input  logic [31:0] ram_val
);

  // Plain-vector state encoding, values taken from the package enum.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_READ  = READ;
  localparam logic [1:0] ST_WRITE = WRITE;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]  state;
  logic [1:0]  state_nxt;

  // Request captured at acceptance. Only the state is reset: every output is
  // decoded from state, so these data registers never leak stale values.
  logic [31:0] addr_q;
  size_e       size_q;
  logic        write_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;

  size_e       req_size_e;
  logic [31:0] req_aligned;
  logic        req_oor;
  logic        req_fault;
  logic        accept;

  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign req_size_e  = size_e'(req_size);
  assign req_aligned = {req_addr[31:2], 2'b00};
  assign req_oor     = ({1'b0, req_aligned} >= 33'(MEM_BYTES));
  assign req_fault   = (req_size_e == SZ_RSVD)
                     || is_misaligned(req_size_e, req_addr[1:0])
                     || req_oor;
  assign accept      = (state == ST_IDLE) && req_valid;

  lsu_lane u_lane (
    .word      (ram_val),
    .lane      (addr_q[1:0]),
    .size      (size_q),
    .zero_ext  (unsigned_q),
    .wdata     (wdata_q[15:0]),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  // Next-state decode: faults skip memory, word stores skip the read.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_fault)                              state_nxt = ST_RESP;
          else if (req_write && req_size_e == SZ_WORD) state_nxt = ST_WRITE;
          else                                        state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = write_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; async reset discards any in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request capture on acceptance, then RAM word capture / merge in READ.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= req_addr;
      size_q     <= req_size_e;
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      wdata_q    <= req_wdata;
      fault_q    <= req_fault;
      rdata_q    <= '0;
    end else if (state == ST_READ) begin
      if (write_q) begin
        word_q  <= lane_merged;
      end else begin
        word_q  <= ram_val;
        rdata_q <= lane_load;
      end
    end
  end

  assign req_ready        = (state == ST_IDLE);
  assign resp_valid       = (state == ST_RESP);
  assign resp_rdata       = resp_valid ? rdata_q : '0;
  assign resp_fault       = resp_valid & fault_q;
  assign ram_write_enable = (state == ST_WRITE);
  assign ram_addr         = (state == ST_READ || state == ST_WRITE) ? {addr_q[31:2], 2'b00} : '0;
  assign ram_set_val      = (state == ST_WRITE) ? ((size_q == SZ_WORD) ? wdata_q : word_q) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word RAM model, a byte-level reference memory
// and randomized plus directed requests checked against that reference.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        ram_write_enable;
  logic [31:0] ram_addr;
  logic [31:0] ram_set_val;
  logic [31:0] ram_val;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(65536)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .ram_write_enable (ram_write_enable),
    .ram_addr         (ram_addr),
    .ram_set_val      (ram_set_val),
    .ram_val          (ram_val)
  );

  // RAM environment with a bench-side poke port, plus activity monitors.
  logic [31:0] ram [0:16383] = '{default: 32'h0};
  logic        poke_en = 1'b0;
  logic [13:0] poke_idx = 14'd0;
  logic [31:0] poke_val = 32'h0;
  int          cyc = 0, wr_count = 0, wr_cyc = 0, resp_count = 0;
  logic [31:0] wr_addr = 32'h0, wr_data = 32'h0;
  logic        bad_align = 1'b0;

  assign ram_val = (ram_addr < 32'h0001_0000) ? ram[ram_addr[15:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_write_enable) begin
      ram[ram_addr[15:2]] <= ram_set_val;
      wr_count <= wr_count + 1;
      wr_addr  <= ram_addr;
      wr_data  <= ram_set_val;
      wr_cyc   <= cyc;
    end else if (poke_en) begin
      ram[poke_idx] <= poke_val;
    end
    if (resp_valid) resp_count <= resp_count + 1;
    if (ram_addr[1:0] != 2'b00) bad_align <= 1'b1;
  end

  // Reference memory, byte granular, little-endian.
  logic [7:0] mb [0:65535];
  int n_checks = 0, n_pass = 0;

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
    longint base;
    base = longint'(a) - longint'(a % 4);
    if (sz == 2'd3) return 1'b1;
    if ((a % (32'd1 << sz)) != 0) return 1'b1;
    return (base >= 65536);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v + (32'(mb[int'(a) + i]) << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) mb[int'(a) + i] = 8'(wd >> (8 * i));
  endfunction

  function automatic int ref_lat(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (ref_fault(sz, a)) return 1;
    if (!w) return 2;
    if (sz == 2'd2) return 2;
    return 3;
  endfunction

  // Observations from the most recent transaction.
  logic [31:0] o_rdata, o_wraddr, o_wrdata;
  logic        o_fault;
  int          o_lat, o_nwr, o_wrrel;

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    poke_en = 1'b1;
    poke_idx = a[15:2];
    poke_val = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
    for (int i = 0; i < 4; i++) mb[(int'(a) & ~3) + i] = 8'(v >> (8 * i));
  endtask

  // Drive one request, wait for its response, record what was seen.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    int guard, wr0, acc;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
    o_lat = 1;
    while (!resp_valid && o_lat < 10) begin @(posedge clk); #1; o_lat++; end
    o_rdata = resp_rdata;
    o_fault = resp_fault;
    o_nwr = wr_count - wr0;
    o_wraddr = wr_addr;
    o_wrdata = wr_data;
    o_wrrel = wr_cyc - acc + 1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({req_ready, resp_valid, resp_fault, ram_write_enable} !== 4'b1000)
      $display("FAIL reset_ctrl got %b want 1000", {req_ready, resp_valid, resp_fault, ram_write_enable});
    else n_pass++;
    n_checks++;
    if ({resp_rdata, ram_addr, ram_set_val} !== 96'h0)
      $display("FAIL reset_data got %h want 0", {resp_rdata, ram_addr, ram_set_val});
    else n_pass++;
  endtask

  task automatic test_loads();
    logic [1:0] sz;
    logic u;
    logic [31:0] a, exp;
    poke(32'h100, 32'h8899AABB);
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin sz = 2'd0; u = (i >= 4); a = 32'h100 + 32'(i % 4); end
      else begin sz = 2'd1; u = (i >= 10); a = 32'h100 + 32'(2 * (i % 2)); end
      exp = ref_load(sz, u, a);
      do_req(1'b0, sz, u, a, $urandom);
      n_checks++;
      if (o_rdata !== exp || o_fault !== 1'b0)
        $display("FAIL load_data addr=%h sz=%0d u=%0d got %h/%b want %h/0", a, sz, u, o_rdata, o_fault, exp);
      else n_pass++;
      n_checks++;
      if (o_lat !== 2) $display("FAIL load_latency addr=%h got %0d want 2", a, o_lat);
      else n_pass++;
    end
    do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    n_checks++;
    if (o_rdata !== 32'hFFFFFFAA) $display("FAIL lb_signed got %h want ffffffaa", o_rdata);
    else n_pass++;
    do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    n_checks++;
    if (o_rdata !== 32'h00008899) $display("FAIL lhu got %h want 00008899", o_rdata);
    else n_pass++;
  endtask

  task automatic test_substore();
    poke(32'h100, 32'h8899AABB);
    ref_store(2'd1, 32'h102, 32'hDEAD1234);
    do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'hDEAD1234);
    n_checks++;
    if (o_nwr !== 1 || o_wraddr !== 32'h100 || o_wrdata !== 32'h1234AABB)
      $display("FAIL sh_write cycles=%0d addr=%h data=%h want 1/00000100/1234aabb", o_nwr, o_wraddr, o_wrdata);
    else n_pass++;
    n_checks++;
    if (o_lat !== 3 || o_rdata !== 32'h0 || o_fault !== 1'b0)
      $display("FAIL sh_resp lat=%0d rdata=%h fault=%b want 3/0/0", o_lat, o_rdata, o_fault);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL resp_pulse valid=%b ready=%b want 0/1", resp_valid, req_ready);
    else n_pass++;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    n_checks++;
    if (o_rdata !== m_word(32'h100)) $display("FAIL lw_after_sh got %h want %h", o_rdata, m_word(32'h100));
    else n_pass++;
    ref_store(2'd0, 32'h103, 32'h77);
    do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h77);
    n_checks++;
    if (o_wrdata !== 32'h7734AABB || o_wrdata !== m_word(32'h100) || o_lat !== 3)
      $display("FAIL sb_merge data=%h lat=%0d want 7734aabb/3", o_wrdata, o_lat);
    else n_pass++;
    ref_store(2'd2, 32'h104, 32'hCAFEF00D);
    do_req(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D);
    n_checks++;
    if (o_wrrel !== 1 || o_lat !== 2 || o_wrdata !== 32'hCAFEF00D || o_wraddr !== 32'h104)
      $display("FAIL sw_timing wrcyc=%0d lat=%0d data=%h addr=%h want 1/2/cafef00d/00000104",
               o_wrrel, o_lat, o_wrdata, o_wraddr);
    else n_pass++;
  endtask

  task automatic test_faults();
    logic [31:0] fa [5] = '{32'h102, 32'h101, 32'h100, 32'h10000, 32'hFFFF_FFFC};
    logic [1:0]  fs [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd0};
    logic        fw [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_req(fw[i], fs[i], 1'b0, fa[i], 32'h5A5A_5A5A);
      n_checks++;
      if (o_fault !== 1'b1 || o_rdata !== 32'h0)
        $display("FAIL fault_flag case=%0d got %b/%h want 1/0", i, o_fault, o_rdata);
      else n_pass++;
      n_checks++;
      if (o_lat !== 1) $display("FAIL fault_latency case=%0d got %0d want 1", i, o_lat);
      else n_pass++;
      n_checks++;
      if (o_nwr !== 0) $display("FAIL fault_nowrite case=%0d got %0d writes want 0", i, o_nwr);
      else n_pass++;
      n_checks++;
      if (ram[64] !== m_word(32'h100) || ram[0] !== m_word(32'h0))
        $display("FAIL fault_mem case=%0d got %h want %h", i, ram[64], m_word(32'h100));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic w, u, ef;
    logic [1:0] sz;
    logic [31:0] a, wd, er;
    int el;
    for (int i = 0; i < 16; i++) poke(32'h200 + 32'(4 * i), $urandom);
    poke(32'hFFF8, $urandom);
    poke(32'hFFFC, $urandom);
    for (int it = 0; it < 80; it++) begin
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 15))
        0:       a = $urandom;
        1, 2:    a = 32'hFFF8 + 32'($urandom_range(0, 15));
        default: a = 32'h200 + 32'($urandom_range(0, 63));
      endcase
      wd = $urandom;
      ef = ref_fault(sz, a);
      el = ref_lat(w, sz, a);
      er = (ef || w) ? 32'h0 : ref_load(sz, u, a);
      if (!ef && w) ref_store(sz, a, wd);
      do_req(w, sz, u, a, wd);
      n_checks++;
      if (o_fault !== ef || o_rdata !== er)
        $display("FAIL rand_resp it=%0d w=%0d sz=%0d a=%h got %b/%h want %b/%h", it, w, sz, a, o_fault, o_rdata, ef, er);
      else n_pass++;
      n_checks++;
      if (o_lat !== el) $display("FAIL rand_latency it=%0d got %0d want %0d", it, o_lat, el);
      else n_pass++;
      n_checks++;
      if (o_nwr !== ((!ef && w) ? 1 : 0))
        $display("FAIL rand_writes it=%0d got %0d want %0d", it, o_nwr, (!ef && w) ? 1 : 0);
      else n_pass++;
      if (!ef && w) begin
        n_checks++;
        if (o_wrdata !== m_word(a) || o_wraddr !== (a & ~32'h3))
          $display("FAIL rand_wdata it=%0d got %h@%h want %h@%h", it, o_wrdata, o_wraddr, m_word(a), a & ~32'h3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [8], wd [8];
    logic [1:0]  s [8];
    logic        w [8];
    int          lat [8];
    int          low, rc0;
    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom;
      a[i] = 32'h200 + 32'(4 * $urandom_range(0, 15));
      case (i % 4)
        0: begin w[i] = 1'b0; s[i] = 2'($urandom_range(0, 2)); end
        1: begin w[i] = 1'($urandom_range(0, 1)); s[i] = 2'd2; a[i] = a[i] + 32'd2; end
        2: begin w[i] = 1'b1; s[i] = 2'd2; end
        default: begin w[i] = 1'b1; s[i] = 2'd0; a[i] = a[i] + 32'($urandom_range(0, 3)); end
      endcase
      lat[i] = ref_lat(w[i], s[i], a[i]);
    end
    repeat (2) @(posedge clk);
    #1;
    rc0 = resp_count;
    req_write = w[0]; req_size = s[0]; req_addr = a[0]; req_wdata = wd[0]; req_unsigned = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      low = 0;
      while (!req_ready && low < 10) begin @(posedge clk); #1; low++; end
      if (i > 0) begin
        n_checks++;
        if (low !== lat[i-1]) $display("FAIL b2b_gap req=%0d got %0d want %0d", i - 1, low, lat[i-1]);
        else n_pass++;
      end
      if (i < 8) begin
        @(posedge clk); #1;
        if (w[i] && !ref_fault(s[i], a[i])) ref_store(s[i], a[i], wd[i]);
        if (i < 7) begin
          req_write = w[i+1]; req_size = s[i+1]; req_addr = a[i+1]; req_wdata = wd[i+1];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (resp_count - rc0 !== 8) $display("FAIL b2b_responses got %0d want 8", resp_count - rc0);
    else n_pass++;
    n_checks++;
    if (ram[128] !== m_word(32'h200) || ram[131] !== m_word(32'h20C))
      $display("FAIL b2b_mem got %h want %h", ram[128], m_word(32'h200));
    else n_pass++;
  endtask

  task automatic test_reset_midwrite();
    int wr0, rc0, guard;
    poke(32'h100, 32'h11223344);
    repeat (2) @(posedge clk);
    #1;
    wr0 = wr_count;
    rc0 = resp_count;
    req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h100; req_wdata = 32'h0000BEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!ram_write_enable && guard < 5) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (ram_write_enable !== 1'b1) $display("FAIL midwrite_reach got we=%b want 1", ram_write_enable);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_write_enable !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL midwrite_async we=%b ready=%b valid=%b want 0/1/0", ram_write_enable, req_ready, resp_valid);
    else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_fault, ram_write_enable} !== 4'b1000 ||
        {resp_rdata, ram_addr, ram_set_val} !== 96'h0)
      $display("FAIL midwrite_outputs got %b %h want 1000 0", {req_ready, resp_valid, resp_fault, ram_write_enable},
               {resp_rdata, ram_addr, ram_set_val});
    else n_pass++;
    n_checks++;
    if (resp_count !== rc0 || wr_count !== wr0)
      $display("FAIL midwrite_discard resp=%0d writes=%0d want 0/0", resp_count - rc0, wr_count - wr0);
    else n_pass++;
    n_checks++;
    if (ram[64] !== m_word(32'h100)) $display("FAIL midwrite_mem got %h want %h", ram[64], m_word(32'h100));
    else n_pass++;
  endtask

  task automatic test_addr_alignment();
    n_checks++;
    if (bad_align !== 1'b0) $display("FAIL ram_addr_aligned got %b want 0", bad_align);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mb[i] = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    test_loads();
    test_substore();
    test_faults();
    test_random();
    test_back_to_back();
    test_reset_midwrite();
    test_addr_alignment();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
